// File: rtl/note_player.sv
// Playback stage for the note recorder: reads a run of stored notes one at a time
// and renders each as a square-wave tone for a fixed number of cycles.
module note_player #(
    parameter int NOTE_CYCLES = 16,
    parameter int TONE_UNIT   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [6:0] start_idx,
    input  logic [7:0] len,
    input  logic [2:0] note_out,
    output logic [1:0] op,
    output logic [6:0] query,
    output logic       busy,
    output logic       done,
    output logic       tone,
    output logic [2:0] cur_note,
    output logic [6:0] cur_idx,
    output logic [7:0] notes_left,
    output logic [1:0] dbg_state
);

    localparam int PW = $clog2(NOTE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_QUERY = 2'd1,
        S_WAIT  = 2'd2,
        S_PLAY  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    cur_idx_q, cur_idx_d;
    logic [7:0]    notes_left_q, notes_left_d;
    logic [2:0]    cur_note_q, cur_note_d;
    logic [PW-1:0] play_cnt_q, play_cnt_d;
    logic [5:0]    tone_cnt_q, tone_cnt_d;
    logic          tone_q, tone_d;
    logic          done_q, done_d;

    logic [2:0]    span;
    logic [5:0]    half;

    // Half-period in cycles: (8 - note) * TONE_UNIT, kept to 6 bits.
    assign span = 3'(4'd8 - {1'b0, cur_note_q});
    assign half = 6'(span * TONE_UNIT);

    // Handshake: start is a one-shot request honoured only while busy is low;
    // the request is accepted on the edge it is sampled and busy rises next cycle.
    always_comb begin
        state_d      = state_q;
        cur_idx_d    = cur_idx_q;
        notes_left_d = notes_left_q;
        cur_note_d   = cur_note_q;
        play_cnt_d   = play_cnt_q;
        tone_cnt_d   = tone_cnt_q;
        tone_d       = tone_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!stop && start) begin
                    if (len != 8'd0) begin
                        state_d      = S_QUERY;
                        cur_idx_d    = start_idx;
                        notes_left_d = len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_QUERY: state_d = S_WAIT;
            S_WAIT: begin
                cur_note_d = note_out;
                play_cnt_d = '0;
                tone_cnt_d = '0;
                tone_d     = 1'b0;
                state_d    = S_PLAY;
            end
            S_PLAY: begin
                if (cur_note_q != 3'd0) begin
                    if (tone_cnt_q == half - 6'd1) begin
                        tone_d     = ~tone_q;
                        tone_cnt_d = '0;
                    end else begin
                        tone_cnt_d = tone_cnt_q + 6'd1;
                    end
                end
                if (play_cnt_q == PW'(NOTE_CYCLES - 1)) begin
                    notes_left_d = notes_left_q - 8'd1;
                    tone_d       = 1'b0;
                    if (notes_left_q == 8'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cur_idx_d = cur_idx_q + 7'd1;
                        state_d   = S_QUERY;
                    end
                end else begin
                    play_cnt_d = play_cnt_q + PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides whatever the active state decided.
        if (stop && state_q != S_IDLE) begin
            state_d      = S_IDLE;
            tone_d       = 1'b0;
            notes_left_d = '0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_idx_q    <= '0;
            notes_left_q <= '0;
            cur_note_q   <= '0;
            play_cnt_q   <= '0;
            tone_cnt_q   <= '0;
            tone_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_idx_q    <= cur_idx_d;
            notes_left_q <= notes_left_d;
            cur_note_q   <= cur_note_d;
            play_cnt_q   <= play_cnt_d;
            tone_cnt_q   <= tone_cnt_d;
            tone_q       <= tone_d;
            done_q       <= done_d;
        end
    end

    assign op         = (state_q == S_QUERY) ? 2'b01 : 2'b10;
    assign query      = cur_idx_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign tone       = tone_q;
    assign cur_note   = cur_note_q;
    assign cur_idx    = cur_idx_q;
    assign notes_left = notes_left_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player with a behavioural recorder model feeding note_out.
module tb_note_player;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic [6:0] start_idx;
  logic [7:0] len;
  logic [2:0] note_out;
  logic [1:0] op;
  logic [6:0] query;
  logic       busy;
  logic       done;
  logic       tone;
  logic [2:0] cur_note;
  logic [6:0] cur_idx;
  logic [7:0] notes_left;
  logic [1:0] dbg_state;

  logic [2:0] mem [128];

  int checks = 0;
  int failures = 0;

  note_player dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .start_idx  (start_idx),
    .len        (len),
    .note_out   (note_out),
    .op         (op),
    .query      (query),
    .busy       (busy),
    .done       (done),
    .tone       (tone),
    .cur_note   (cur_note),
    .cur_idx    (cur_idx),
    .notes_left (notes_left),
    .dbg_state  (dbg_state)
  );

  // clock / recorder model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (op == 2'b01) note_out <= mem[query];
  end

  // driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_tone(input int note, input int p);
    int half;
    if (note == 0) return 0;
    half = (8 - note) * 2;
    return (p / half) % 2;
  endfunction

  // Play a run to completion and check every cycle S+1 .. S+18*n+2.
  task automatic run_play(input int sidx, input int n);
    int k;
    int q;
    logic [6:0] idx;
    start_idx = 7'(sidx);
    len = 8'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 18 * n + 1; c++) begin
      k = (c - 1) / 18;
      q = (c - 1) % 18;
      idx = 7'(sidx + k);
      if (c <= 18 * n) begin
        check("busy", 32'(busy), 1);
        check("done_low", 32'(done), 0);
        check("op", 32'(op), (q == 0) ? 1 : 2);
        check("notes_left", 32'(notes_left), n - k);
        check("cur_idx", 32'(cur_idx), 32'(idx));
        if (q == 0) check("query", 32'(query), 32'(idx));
        if (q >= 2) begin
          check("cur_note", 32'(cur_note), 32'(mem[idx]));
          check("tone", 32'(tone), exp_tone(int'(mem[idx]), q - 2));
        end else begin
          check("tone_idle", 32'(tone), 0);
        end
      end else begin
        check("done", 32'(done), 1);
        check("busy_end", 32'(busy), 0);
        check("op_end", 32'(op), 2);
        check("notes_left_end", 32'(notes_left), 0);
        check("tone_end", 32'(tone), 0);
      end
      tick();
    end
    check("done_pulse", 32'(done), 0);
    check("state_idle", 32'(dbg_state), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_op"}, 32'(op), 2);
    check({tag, "_query"}, 32'(query), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_tone"}, 32'(tone), 0);
    check({tag, "_cur_note"}, 32'(cur_note), 0);
    check({tag, "_cur_idx"}, 32'(cur_idx), 0);
    check({tag, "_notes_left"}, 32'(notes_left), 0);
    check({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 3'(i % 8);
    mem[127] = 3'd5;
    mem[126] = 3'd1;
    mem[0]   = 3'd7;
    mem[1]   = 3'd0;
    note_out = 3'd0;
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    start_idx = 7'd0;
    len = 8'd0;
    tick();
    tick();
    check_reset_values("rst");
    reset = 1'b0;
    tick();
    check_reset_values("post_rst");

    // single note at the newest entry (note 5, half-period 6)
    run_play(127, 1);
    // wrap 126,127,0,1 covering notes 1,5,7 and a rest
    run_play(126, 4);
    // rest alone, then highest pitch alone
    run_play(1, 1);
    run_play(0, 1);

    // abort at S+10 with an ignored second start at S+5
    start_idx = 7'd10;
    len = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check("abort_busy", 32'(busy), 1);
      check("abort_notes_left", 32'(notes_left), 3);
      check("abort_cur_idx", 32'(cur_idx), 10);
      start = (c == 5);
      if (c == 5) begin
        start_idx = 7'd50;
        len = 8'd9;
      end
      stop = (c == 10);
      tick();
    end
    start = 1'b0;
    stop = 1'b0;
    check("abort_busy_low", 32'(busy), 0);
    check("abort_state", 32'(dbg_state), 0);
    check("abort_tone", 32'(tone), 0);
    check("abort_op", 32'(op), 2);
    check("abort_notes_left0", 32'(notes_left), 0);
    check("abort_no_done", 32'(done), 0);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("abort_quiet_done", 32'(done), 0);
      check("abort_quiet_op", 32'(op), 2);
      check("abort_quiet_busy", 32'(busy), 0);
    end

    // start and stop together in IDLE: start ignored
    start_idx = 7'd3;
    len = 8'd3;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check("ss_busy", 32'(busy), 0);
    check("ss_done", 32'(done), 0);
    check("ss_op", 32'(op), 2);
    tick();
    check("ss_busy2", 32'(busy), 0);

    // zero length: done at S+1, never busy, never queries
    len = 8'd0;
    start_idx = 7'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", 32'(done), 1);
    check("zero_busy", 32'(busy), 0);
    check("zero_op", 32'(op), 2);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("zero_done_low", 32'(done), 0);
      check("zero_busy_low", 32'(busy), 0);
      check("zero_op_hold", 32'(op), 2);
    end

    // reset mid-PLAY
    start_idx = 7'd127;
    len = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    check("mid_busy", 32'(busy), 1);
    check("mid_state_play", 32'(dbg_state), 3);
    check("mid_cur_note", 32'(cur_note), 5);
    reset = 1'b1;
    tick();
    check_reset_values("mid_rst");
    reset = 1'b0;
    tick();
    check_reset_values("mid_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
